deframing: RTL and testbench

Receive side of the framed burst stream. Accepts back-to-back frames of `FRAME_LEN` samples delimited by `last_i`, for example the FFT-bound output of the framing stage. Checks each frame's length and commits only well-formed frames into a two-frame buffer. Re-emits the committed samples as an evenly paced stream of one sample every `PACE_CYCLES` cycles for downstream sample-rate consumers.

---
 rtl/deframing_pkg.sv | 21 ++
 rtl/sdp_ram.sv | 37 +++
 rtl/deframing.sv | 160 ++++++++++++++++
 tb/tb_deframing.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/deframing_pkg.sv
// deframing_pkg: shared frame constants, receiver state encoding and a width helper (rev 1.0)
`default_nettype none

package deframing_pkg;

  localparam int DEF_DATA_BW   = 16;
  localparam int DEF_FRAME_LEN = 256;

  typedef enum logic [0:0] {
    RX_ACCEPT  = 1'b0,
    RX_DISCARD = 1'b1
  } rx_state_t;

  // Counter width for a 0..n-1 range; a single-value range still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port (rev 1.0)
`default_nettype none

module sdp_ram #(
  parameter int DATA_BW = 16,
  parameter int DEPTH   = 512
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_BW-1:0]         i_wdata,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_BW-1:0]         o_rdata
);

  logic [DATA_BW-1:0] r_mem [DEPTH];
  logic [DATA_BW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The read register holds between reads, which keeps the output sample stable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re)  r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/deframing.sv
// deframing: length-checked commit of framed bursts into a buffer, re-emitted at a fixed pace (rev 1.0)
`default_nettype none

module deframing
  import deframing_pkg::*;
#(
  parameter int DATA_BW     = DEF_DATA_BW,
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int FIFO_DEPTH  = 512,
  parameter int PACE_CYCLES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic signed [DATA_BW-1:0] data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic signed [DATA_BW-1:0] data_o,
  output logic                      valid_o,
  output logic                      last_o,
  output logic                      err_short_o,
  output logic                      err_long_o,
  output logic                      overflow_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = cnt_width(FRAME_LEN);
  localparam int PCW = cnt_width(PACE_CYCLES);

  rx_state_t        r_state, w_state_nxt;
  logic [PW-1:0]    r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [PW-1:0]    w_wr_ptr_nxt, w_cm_ptr_nxt, w_used, w_free;
  logic [CW-1:0]    r_rx_cnt, w_rx_cnt_nxt, r_tx_cnt;
  logic [PCW-1:0]   r_pace_cnt;
  logic             w_wr_en, w_err_short, w_err_long, w_ovf;
  logic             w_tick, w_rd, w_rx_full;
  logic             r_valid, r_last, r_err_short, r_err_long, r_ovf;
  logic [DATA_BW-1:0] w_rdata;

  assign w_used    = r_cm_ptr - r_rd_ptr;
  assign w_free    = PW'(FIFO_DEPTH) - (r_wr_ptr - r_rd_ptr);
  assign w_tick    = (r_pace_cnt == '0);
  assign w_rd      = w_tick && (w_used != '0);
  assign w_rx_full = (r_rx_cnt == CW'(FRAME_LEN - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_cm_ptr_nxt = r_cm_ptr;
    w_rx_cnt_nxt = r_rx_cnt;
    w_wr_en      = 1'b0;
    w_err_short  = 1'b0;
    w_err_long   = 1'b0;
    w_ovf        = 1'b0;
    case (r_state)
      RX_ACCEPT: begin
        if (valid_i) begin
          // Space is only judged at a frame's first beat; a started frame always fits.
          if ((r_rx_cnt == '0) && (w_free < PW'(FRAME_LEN))) begin
            w_ovf = 1'b1;
            if (!last_i) w_state_nxt = RX_DISCARD;
          end else if (last_i && !w_rx_full) begin
            w_wr_ptr_nxt = r_cm_ptr;
            w_rx_cnt_nxt = '0;
            w_err_short  = 1'b1;
          end else if (w_rx_full && last_i) begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            w_cm_ptr_nxt = r_wr_ptr + 1'b1;
            w_rx_cnt_nxt = '0;
          end else if (w_rx_full) begin
            w_wr_ptr_nxt = r_cm_ptr;
            w_rx_cnt_nxt = '0;
            w_err_long   = 1'b1;
            w_state_nxt  = RX_DISCARD;
          end else begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            w_rx_cnt_nxt = r_rx_cnt + 1'b1;
          end
        end
      end
      RX_DISCARD: begin
        if (valid_i && last_i) w_state_nxt = RX_ACCEPT;
      end
      default: w_state_nxt = RX_ACCEPT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= RX_ACCEPT;
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
      r_pace_cnt  <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (!en_i) begin
      r_state     <= RX_ACCEPT;
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
      r_pace_cnt  <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_cm_ptr    <= w_cm_ptr_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_err_short <= w_err_short;
      r_err_long  <= w_err_long;
      r_ovf       <= w_ovf;
      r_pace_cnt  <= (r_pace_cnt == PCW'(PACE_CYCLES - 1)) ? '0 : r_pace_cnt + 1'b1;
      r_valid     <= w_rd;
      r_last      <= w_rd && (r_tx_cnt == CW'(FRAME_LEN - 1));
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_tx_cnt <= (r_tx_cnt == CW'(FRAME_LEN - 1)) ? '0 : r_tx_cnt + 1'b1;
      end
    end
  end

  sdp_ram #(
    .DATA_BW (DATA_BW),
    .DEPTH   (FIFO_DEPTH)
  ) u_ram (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_clr   (!en_i),
    .i_we    (w_wr_en && en_i),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (data_i),
    .i_re    (w_rd && en_i),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign data_o      = w_rdata;
  assign valid_o     = r_valid;
  assign last_o      = r_last;
  assign err_short_o = r_err_short;
  assign err_long_o  = r_err_long;
  assign overflow_o  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_deframing.sv
// tb_deframing: three pacings driven by one stream, checked against a queue-level frame model
`default_nettype none

module tb_deframing;

  localparam int DW    = 16;
  localparam int FL    = 4;
  localparam int DEPTH = 8;
  localparam int NI    = 3;
  localparam int QN    = 4096;
  localparam int LN    = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic signed [DW-1:0] din = '0;
  logic vin = 1'b0;
  logic lin = 1'b0;

  logic signed [DW-1:0] d_o [NI];
  logic v_o [NI], l_o [NI], es_o [NI], el_o [NI], ov_o [NI];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  deframing #(.DATA_BW(DW), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .PACE_CYCLES(2)) u_dut_p2 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(din), .valid_i(vin), .last_i(lin),
    .data_o(d_o[0]), .valid_o(v_o[0]), .last_o(l_o[0]),
    .err_short_o(es_o[0]), .err_long_o(el_o[0]), .overflow_o(ov_o[0]));

  deframing #(.DATA_BW(DW), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .PACE_CYCLES(1)) u_dut_p1 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(din), .valid_i(vin), .last_i(lin),
    .data_o(d_o[1]), .valid_o(v_o[1]), .last_o(l_o[1]),
    .err_short_o(es_o[1]), .err_long_o(el_o[1]), .overflow_o(ov_o[1]));

  deframing #(.DATA_BW(DW), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .PACE_CYCLES(8)) u_dut_p8 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(din), .valid_i(vin), .last_i(lin),
    .data_o(d_o[2]), .valid_o(v_o[2]), .last_o(l_o[2]),
    .err_short_o(es_o[2]), .err_long_o(el_o[2]), .overflow_o(ov_o[2]));

  function automatic int pace_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
  endfunction

  function automatic logic [31:0] pk(input logic [DW-1:0] d, input logic v, input logic l,
                                     input logic es, input logic el, input logic ov);
    return {11'd0, d, v, l, es, el, ov};
  endfunction

  function automatic logic [31:0] lgx(input logic l, input logic [DW-1:0] d);
    return {15'd0, l, d};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, k, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: pending frame + committed sample queue ----------------
  int m_disc [NI], m_pn [NI], m_h [NI], m_t [NI], m_cyc [NI], m_oc [NI];
  logic [DW-1:0] m_pend [NI][FL];
  logic [DW-1:0] m_cq   [NI][QN];
  logic [DW-1:0] e_d [NI];
  logic e_v [NI], e_l [NI], e_es [NI], e_el [NI], e_ov [NI];

  task automatic model_clear(input int k);
    m_disc[k] = 0; m_pn[k] = 0; m_h[k] = 0; m_t[k] = 0; m_cyc[k] = 0; m_oc[k] = 0;
    e_d[k] = '0; e_v[k] = 0; e_l[k] = 0; e_es[k] = 0; e_el[k] = 0; e_ov[k] = 0;
  endtask

  task automatic model_step(input int k);
    int used, free;
    bit rd;
    used = m_t[k] - m_h[k];
    free = DEPTH - (m_pn[k] + used);
    rd = ((m_cyc[k] % pace_of(k)) == 0) && (used > 0);
    e_v[k] = rd; e_l[k] = 0; e_es[k] = 0; e_el[k] = 0; e_ov[k] = 0;
    if (rd) begin
      e_d[k] = m_cq[k][m_h[k] % QN];
      e_l[k] = (m_oc[k] == FL - 1);
      m_oc[k] = (m_oc[k] + 1) % FL;
      m_h[k]++;
    end
    m_cyc[k]++;
    if (m_disc[k] != 0) begin
      if (vin && lin) m_disc[k] = 0;
    end else if (vin) begin
      if (m_pn[k] == 0 && free < FL) begin
        e_ov[k] = 1;
        if (!lin) m_disc[k] = 1;
      end else if (lin && m_pn[k] < FL - 1) begin
        e_es[k] = 1; m_pn[k] = 0;
      end else if (m_pn[k] == FL - 1) begin
        if (lin) begin
          for (int i = 0; i < FL - 1; i++) begin
            m_cq[k][m_t[k] % QN] = m_pend[k][i];
            m_t[k]++;
          end
          m_cq[k][m_t[k] % QN] = din;
          m_t[k]++;
        end else begin
          e_el[k] = 1; m_disc[k] = 1;
        end
        m_pn[k] = 0;
      end else begin
        m_pend[k][m_pn[k]] = din;
        m_pn[k]++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) model_clear(k);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n || !en) model_clear(k);
        else model_step(k);
      end
    end
  end

  // ---------------- per-cycle compare and output logging ----------------
  logic [16:0] lg   [NI][LN];
  int          vcy  [NI][LN];
  int          ln   [NI];
  int          n_es [NI], n_el [NI], n_ov [NI];

  initial begin
    for (int k = 0; k < NI; k++) begin
      ln[k] = 0; n_es[k] = 0; n_el[k] = 0; n_ov[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("cycle", k, pk(d_o[k], v_o[k], l_o[k], es_o[k], el_o[k], ov_o[k]),
            pk(e_d[k], e_v[k], e_l[k], e_es[k], e_el[k], e_ov[k]));
        if (v_o[k] && ln[k] < LN) begin
          lg[k][ln[k]]  = {l_o[k], d_o[k]};
          vcy[k][ln[k]] = cyc_n;
          ln[k]++;
        end
        n_es[k] += int'(es_o[k]);
        n_el[k] += int'(el_o[k]);
        n_ov[k] += int'(ov_o[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int last_cyc;

  task automatic beat(input int d, input logic l);
    @(negedge clk);
    vin = 1'b1; din = DW'(d); lin = l;
    if (l) last_cyc = cyc_n;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = 1'b0; lin = 1'b0; din = DW'($urandom);
    end
  endtask

  task automatic good(input int base);
    for (int i = 0; i < FL; i++) beat(base + i, (i == FL - 1));
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic expect_frame(input string name, input int k, input int idx, input int base);
    for (int i = 0; i < FL; i++)
      chk(name, k, lgx(lg[k][idx + i][16], lg[k][idx + i][15:0]), lgx(i == FL - 1, DW'(base + i)));
  endtask

  initial begin
    int f0, f1, f2, es0, el0, ov2, tgt, cnt, dens, r;
    repeat (2) @(negedge clk);
    chk("reset_state", 0, pk(d_o[0], v_o[0], l_o[0], es_o[0], el_o[0], ov_o[0]), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // good frame
    good(10); idle(50); settle();
    expect_frame("good_frame", 0, 0, 10);
    chk("good_pace", 0, 32'(vcy[0][1] - vcy[0][0]), 32'd2);
    chk("good_no_err", 0, 32'(n_es[0] + n_el[0] + n_ov[0]), 32'd0);

    // short frame then good
    beat(1, 1'b0); beat(2, 1'b1); good(5); idle(50); settle();
    chk("short_pulse", 0, 32'(n_es[0]), 32'd1);
    expect_frame("short_then_good", 0, 4, 5);

    // long frame: 6 beats, last on the 6th, then good
    for (int i = 0; i < 6; i++) beat(30 + i, (i == 5));
    good(20); idle(50); settle();
    chk("long_pulse", 0, 32'(n_el[0]), 32'd1);
    expect_frame("long_then_good", 0, 8, 20);
    chk("long_count", 0, 32'(ln[0]), 32'd12);

    // three back-to-back frames; the slow pacing must overflow on the third
    f2 = ln[2]; ov2 = n_ov[2];
    good(40); good(50); good(60); idle(60); settle();
    chk("ovf_pulse", 2, 32'(n_ov[2] - ov2), 32'd1);
    chk("ovf_count", 2, 32'(ln[2] - f2), 32'd8);
    expect_frame("ovf_f1", 2, f2, 40);
    expect_frame("ovf_f2", 2, f2 + 4, 50);

    // full-rate drain
    f1 = ln[1];
    good(70); r = last_cyc; good(80); idle(30); settle();
    chk("full_latency", 1, 32'(vcy[1][f1]), 32'(r + 2));
    chk("full_span", 1, 32'(vcy[1][f1 + 7] - vcy[1][f1]), 32'd7);
    expect_frame("full_f1", 1, f1, 70);
    expect_frame("full_f2", 1, f1 + 4, 80);

    // asynchronous reset mid-frame
    beat(1, 1'b0); beat(2, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0; vin = 1'b0; lin = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      chk("async_rst", k, pk(d_o[k], v_o[k], l_o[k], es_o[k], el_o[k], ov_o[k]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = ln[0]; es0 = n_es[0]; el0 = n_el[0];
    good(90); idle(30); settle();
    expect_frame("after_rst", 0, f0, 90);
    chk("after_rst_err", 0, 32'(n_es[0] - es0 + n_el[0] - el0), 32'd0);

    // one-cycle enable drop mid-drain
    f0 = ln[0];
    good(100); idle(4);
    @(negedge clk); en = 1'b0; vin = 1'b0; lin = 1'b0;
    @(negedge clk); en = 1'b1;
    idle(5); good(110); idle(30); settle();
    chk("en_lost", 0, 32'(ln[0] - f0 < 8), 32'd1);
    expect_frame("en_next", 0, ln[0] - 4, 110);

    // randomized traffic
    tgt = FL; cnt = 0; dens = 90;
    for (int c = 0; c < 1600; c++) begin
      if (c % 200 == 0) dens = (c % 800 == 0) ? 90 : ((c % 800 == 200) ? 30 : ((c % 800 == 400) ? 60 : 100));
      @(negedge clk);
      en  = ($urandom_range(0, 299) != 0);
      vin = ($urandom_range(0, 99) < dens);
      din = DW'($urandom);
      lin = 1'b0;
      if (vin) begin
        cnt++;
        lin = (cnt == tgt) || ($urandom_range(0, 49) == 0);
        if (lin) begin
          cnt = 0;
          r = $urandom_range(0, 7);
          tgt = (r < 5) ? FL : ((r == 5) ? 2 : ((r == 6) ? 6 : 1));
        end
      end
    end
    en = 1'b1;
    idle(80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
